// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR/trap unit: CSR addresses, mstatus/mip bit positions,
// interrupt cause codes, csr_op encodings and the per-cycle action selector.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LO   = 11;
    localparam int unsigned MSTATUS_MPP_HI   = 12;

    localparam int unsigned MIP_MTIP_BIT = 7;
    localparam int unsigned MIP_MEIP_BIT = 11;

    localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
    localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_EXC,
        ACT_IRQ,
        ACT_MRET,
        ACT_WRITE
    } action_e;

endpackage

// File: rtl/csr_trap_unit_if.sv
// Execute-stage <-> CSR/trap unit connection: CSR access, trap inputs and redirect outputs.
interface csr_trap_unit_if #(
    parameter int unsigned DATA_LEN = 32
);
    logic                inst_valid;
    logic [1:0]          csr_op;
    logic                csr_ren;
    logic [11:0]         addr;
    logic [DATA_LEN-1:0] wdata;
    logic [DATA_LEN-1:0] pc;
    logic                exc_valid;
    logic [DATA_LEN-1:0] exc_cause;
    logic                mret;
    logic                irq_timer;
    logic                irq_ext;
    logic [DATA_LEN-1:0] rdata;
    logic                illegal;
    logic                trap_take;
    logic [DATA_LEN-1:0] trap_pc;

    modport master (
        output inst_valid, csr_op, csr_ren, addr, wdata, pc,
               exc_valid, exc_cause, mret, irq_timer, irq_ext,
        input  rdata, illegal, trap_take, trap_pc
    );

    modport slave (
        input  inst_valid, csr_op, csr_ren, addr, wdata, pc,
               exc_valid, exc_cause, mret, irq_timer, irq_ext,
        output rdata, illegal, trap_take, trap_pc
    );
endinterface

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit counter with increment enable and independent 32-bit half write ports;
// any half write replaces the increment for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        lo_we,
    input  logic [31:0] lo_wdata,
    input  logic        hi_we,
    input  logic [31:0] hi_wdata,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (lo_we || hi_we) begin
            count <= {hi_we ? hi_wdata : count[63:32], lo_we ? lo_wdata : count[31:0]};
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry, mret, interrupt enable/pending and 64-bit cycle/instret counters.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int unsigned DATA_LEN         = 32,
    parameter logic [31:0] MSTATUS_RST_DATA = 32'h1800,
    parameter bit          HAS_COUNTERS     = 1'b1
) (
    input logic            clk,
    input logic            rst,
    csr_trap_unit_if.slave bus
);

    typedef logic [DATA_LEN-1:0] xword_t;

    logic    mie_bit;
    logic    mpie_bit;
    xword_t  mie_q;
    xword_t  mtvec_q;
    xword_t  mscratch_q;
    xword_t  mepc_q;
    xword_t  mcause_q;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    csr_op_e op;
    action_e action;
    xword_t  mstatus_rd;
    xword_t  mip_rd;
    xword_t  old_val;
    xword_t  new_val;
    xword_t  irq_hits;
    xword_t  tvec_base;
    logic [63:0] new64;
    logic    addr_ok;
    logic    access;
    logic    write_req;
    logic    ro_target;
    logic    illegal;
    logic    irq_pend;
    logic [3:0] irq_code;

    logic        cyc_lo_we, cyc_hi_we, ir_lo_we, ir_hi_we;
    logic [31:0] cnt_lo_data, cnt_hi_data;
    logic        instret_inc;

    assign op = csr_op_e'(bus.csr_op);

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE_BIT]  = mie_bit;
        mstatus_rd[MSTATUS_MPIE_BIT] = mpie_bit;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mip_rd = '0;
        mip_rd[MIP_MTIP_BIT] = bus.irq_timer;
        mip_rd[MIP_MEIP_BIT] = bus.irq_ext;
    end

    always_comb begin
        addr_ok = 1'b0;
        old_val = '0;
        case (bus.addr)
            CSR_MSTATUS:  begin addr_ok = 1'b1; old_val = mstatus_rd; end
            CSR_MIE:      begin addr_ok = 1'b1; old_val = mie_q;      end
            CSR_MTVEC:    begin addr_ok = 1'b1; old_val = mtvec_q;    end
            CSR_MSCRATCH: begin addr_ok = 1'b1; old_val = mscratch_q; end
            CSR_MEPC:     begin addr_ok = 1'b1; old_val = mepc_q;     end
            CSR_MCAUSE:   begin addr_ok = 1'b1; old_val = mcause_q;   end
            CSR_MIP:      begin addr_ok = 1'b1; old_val = mip_rd;     end
            CSR_MHARTID:  begin addr_ok = 1'b1; old_val = '0;         end
            CSR_MCYCLE: begin
                addr_ok = HAS_COUNTERS;
                old_val = xword_t'(cycle_cnt);
            end
            CSR_MINSTRET: begin
                addr_ok = HAS_COUNTERS;
                old_val = xword_t'(instret_cnt);
            end
            CSR_MCYCLEH: begin
                addr_ok = HAS_COUNTERS && (DATA_LEN == 32);
                old_val = xword_t'(cycle_cnt[63:32]);
            end
            CSR_MINSTRETH: begin
                addr_ok = HAS_COUNTERS && (DATA_LEN == 32);
                old_val = xword_t'(instret_cnt[63:32]);
            end
            default: ;
        endcase
        if (!addr_ok) old_val = '0;
    end

    always_comb begin
        case (op)
            CSR_OP_RW: new_val = bus.wdata;
            CSR_OP_RS: new_val = old_val | bus.wdata;
            CSR_OP_RC: new_val = old_val & ~bus.wdata;
            default:   new_val = old_val;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it may target read-only CSRs.
    assign write_req = (op == CSR_OP_RW) || (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (|bus.wdata));
    assign access    = (op != CSR_OP_NONE) || bus.csr_ren;
    assign ro_target = (bus.addr == CSR_MIP) || (bus.addr == CSR_MHARTID);
    assign illegal   = access && (!addr_ok || (write_req && ro_target));

    assign bus.illegal = illegal;
    assign bus.rdata   = (bus.csr_ren && !illegal) ? old_val : '0;

    assign irq_hits = mip_rd & mie_q;
    assign irq_pend = mie_bit && (|irq_hits);
    assign irq_code = irq_hits[MIP_MEIP_BIT] ? IRQ_CODE_EXT : IRQ_CODE_TIMER;

    always_comb begin
        action = ACT_NONE;
        if (bus.inst_valid) begin
            if (bus.exc_valid)             action = ACT_EXC;
            else if (irq_pend)             action = ACT_IRQ;
            else if (bus.mret)             action = ACT_MRET;
            else if (write_req && !illegal) action = ACT_WRITE;
        end
    end

    assign tvec_base = mtvec_q & ~xword_t'(3);

    always_comb begin
        bus.trap_take = 1'b0;
        bus.trap_pc   = '0;
        case (action)
            ACT_EXC: begin
                bus.trap_take = 1'b1;
                bus.trap_pc   = tvec_base;
            end
            ACT_IRQ: begin
                bus.trap_take = 1'b1;
                bus.trap_pc   = (mtvec_q[1:0] == 2'b01) ? tvec_base + xword_t'({irq_code, 2'b00}) : tvec_base;
            end
            ACT_MRET: begin
                bus.trap_take = 1'b1;
                bus.trap_pc   = mepc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_bit    <= MSTATUS_RST_DATA[MSTATUS_MIE_BIT];
            mpie_bit   <= MSTATUS_RST_DATA[MSTATUS_MPIE_BIT];
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            case (action)
                ACT_EXC, ACT_IRQ: begin
                    mepc_q   <= bus.pc & ~xword_t'(3);
                    mcause_q <= (action == ACT_EXC) ? bus.exc_cause : {1'b1, (DATA_LEN-1)'(irq_code)};
                    mpie_bit <= mie_bit;
                    mie_bit  <= 1'b0;
                end
                ACT_MRET: begin
                    mie_bit  <= mpie_bit;
                    mpie_bit <= 1'b1;
                end
                ACT_WRITE: begin
                    case (bus.addr)
                        CSR_MSTATUS: begin
                            mie_bit  <= new_val[MSTATUS_MIE_BIT];
                            mpie_bit <= new_val[MSTATUS_MPIE_BIT];
                        end
                        CSR_MIE:      mie_q      <= new_val;
                        CSR_MTVEC:    mtvec_q    <= (new_val[1:0] == 2'b01) ? new_val : (new_val & ~xword_t'(3));
                        CSR_MSCRATCH: mscratch_q <= new_val;
                        CSR_MEPC:     mepc_q     <= new_val & ~xword_t'(3);
                        CSR_MCAUSE:   mcause_q   <= new_val;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // At XLEN=64 the low-half address writes the whole counter through both half ports.
    assign new64       = 64'(new_val);
    assign cnt_lo_data = new64[31:0];
    assign cnt_hi_data = (DATA_LEN == 64) ? new64[63:32] : new64[31:0];

    always_comb begin
        cyc_lo_we = 1'b0;
        cyc_hi_we = 1'b0;
        ir_lo_we  = 1'b0;
        ir_hi_we  = 1'b0;
        if (action == ACT_WRITE) begin
            case (bus.addr)
                CSR_MCYCLE:    begin cyc_lo_we = 1'b1; cyc_hi_we = (DATA_LEN == 64); end
                CSR_MINSTRET:  begin ir_lo_we  = 1'b1; ir_hi_we  = (DATA_LEN == 64); end
                CSR_MCYCLEH:   cyc_hi_we = 1'b1;
                CSR_MINSTRETH: ir_hi_we  = 1'b1;
                default: ;
            endcase
        end
    end

    assign instret_inc = bus.inst_valid && (action != ACT_EXC) && (action != ACT_IRQ);

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counter64 u_mcycle (
                .clk      (clk),
                .rst      (rst),
                .inc_en   (1'b1),
                .lo_we    (cyc_lo_we),
                .lo_wdata (cnt_lo_data),
                .hi_we    (cyc_hi_we),
                .hi_wdata (cnt_hi_data),
                .count    (cycle_cnt)
            );
            csr_counter64 u_minstret (
                .clk      (clk),
                .rst      (rst),
                .inc_en   (instret_inc),
                .lo_we    (ir_lo_we),
                .lo_wdata (cnt_lo_data),
                .hi_we    (ir_hi_we),
                .hi_wdata (cnt_hi_data),
                .count    (instret_cnt)
            );
        end else begin : g_no_counters
            assign cycle_cnt   = '0;
            assign instret_cnt = '0;
        end
    endgenerate

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit (XLEN=32): a driver predicts each cycle's outputs from a
// behavioural CSR model and queues them; a negedge monitor pops and compares.
module tb_csr_trap_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_trap_unit_if #(.DATA_LEN(32)) bus ();

    csr_trap_unit #(
        .DATA_LEN         (32),
        .MSTATUS_RST_DATA (32'h1800),
        .HAS_COUNTERS     (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic        take;
        logic [31:0] tpc;
        int          step_no;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_cnt = 0;

    // Architectural model state
    bit        m_ie, m_pie;
    bit [31:0] m_mie, m_mtvec, m_scratch, m_mepc, m_mcause;
    bit [63:0] m_cyc, m_ir;

    task automatic model_reset();
        m_ie = 1'b0; m_pie = 1'b0;
        m_mie = 0; m_mtvec = 0; m_scratch = 0; m_mepc = 0; m_mcause = 0;
        m_cyc = 0; m_ir = 0;
    endtask

    task automatic idle_inputs();
        bus.inst_valid = 0; bus.csr_op = 0; bus.csr_ren = 0; bus.addr = 0; bus.wdata = 0;
        bus.pc = 0; bus.exc_valid = 0; bus.exc_cause = 0; bus.mret = 0;
        bus.irq_timer = 0; bus.irq_ext = 0;
    endtask

    task automatic do_reset(bit iv, bit exc);
        @(posedge clk); #1;
        idle_inputs();
        bus.inst_valid = iv;
        bus.exc_valid  = exc;
        bus.exc_cause  = 32'd2;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        idle_inputs();
        model_reset();
    endtask

    task automatic step(bit iv, bit [1:0] op, bit ren, bit [11:0] a, bit [31:0] w,
                        bit [31:0] pcv, bit exc, bit [31:0] cause, bit mr, bit tmr, bit ext);
        bit        ok, wr, ill, pend, take, cyc_w, ir_w;
        bit [31:0] val, nv, tpc, mip;
        bit [3:0]  code;
        exp_t      e;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.inst_valid = iv; bus.csr_op = op; bus.csr_ren = ren; bus.addr = a; bus.wdata = w;
        bus.pc = pcv; bus.exc_valid = exc; bus.exc_cause = cause; bus.mret = mr;
        bus.irq_timer = tmr; bus.irq_ext = ext;

        mip = (ext ? 32'h800 : 0) | (tmr ? 32'h80 : 0);
        ok = 1'b1;
        case (a)
            12'h300: val = 32'h1800 | (m_ie ? 32'h8 : 0) | (m_pie ? 32'h80 : 0);
            12'h304: val = m_mie;
            12'h305: val = m_mtvec;
            12'h340: val = m_scratch;
            12'h341: val = m_mepc;
            12'h342: val = m_mcause;
            12'h344: val = mip;
            12'hF14: val = 0;
            12'hB00: val = m_cyc[31:0];
            12'hB02: val = m_ir[31:0];
            12'hB80: val = m_cyc[63:32];
            12'hB82: val = m_ir[63:32];
            default: begin ok = 1'b0; val = 0; end
        endcase
        wr  = (op == 2'b01) || (op[1] && w != 0);
        ill = (op != 0 || ren) && (!ok || (wr && (a == 12'h344 || a == 12'hF14)));
        pend = m_ie && ((ext && m_mie[11]) || (tmr && m_mie[7]));
        code = (ext && m_mie[11]) ? 4'd11 : 4'd7;

        take = 0; tpc = 0; cyc_w = 0; ir_w = 0;
        if (iv && exc) begin
            take = 1; tpc = m_mtvec & ~32'd3;
            m_mepc = pcv & ~32'd3; m_mcause = cause; m_pie = m_ie; m_ie = 0;
        end else if (iv && pend) begin
            take = 1;
            tpc = (m_mtvec & ~32'd3) + ((m_mtvec[1:0] == 2'b01) ? 32'(code) * 4 : 0);
            m_mepc = pcv & ~32'd3; m_mcause = 32'h8000_0000 | 32'(code); m_pie = m_ie; m_ie = 0;
        end else if (iv && mr) begin
            take = 1; tpc = m_mepc;
            m_ie = m_pie; m_pie = 1;
        end else if (iv && wr && !ill) begin
            nv = (op == 2'b01) ? w : (op == 2'b10) ? (val | w) : (val & ~w);
            case (a)
                12'h300: begin m_ie = nv[3]; m_pie = nv[7]; end
                12'h304: m_mie = nv;
                12'h305: m_mtvec = (nv[1:0] == 2'b01) ? nv : (nv & ~32'd3);
                12'h340: m_scratch = nv;
                12'h341: m_mepc = nv & ~32'd3;
                12'h342: m_mcause = nv;
                12'hB00: begin m_cyc[31:0]  = nv; cyc_w = 1; end
                12'hB80: begin m_cyc[63:32] = nv; cyc_w = 1; end
                12'hB02: begin m_ir[31:0]   = nv; ir_w = 1; end
                12'hB82: begin m_ir[63:32]  = nv; ir_w = 1; end
                default: ;
            endcase
        end
        if (!cyc_w) m_cyc = m_cyc + 1;
        if (!ir_w && iv && !(exc || pend)) m_ir = m_ir + 1;

        e.rdata   = (ren && !ill) ? val : 0;
        e.illegal = ill;
        e.take    = take;
        e.tpc     = tpc;
        e.step_no = step_cnt;
        step_cnt++;
        q.push_back(e);
    endtask

    task automatic rd(bit [11:0] a);
        step(1, 2'b00, 1, a, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
    endtask

    task automatic csr(bit [1:0] op, bit [11:0] a, bit [31:0] w);
        step(1, op, 1, a, w, 32'h8000_0000, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(string name, int sn, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, sn, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rdata",     e.step_no, bus.rdata,             e.rdata);
                chk("illegal",   e.step_no, 32'(bus.illegal),      32'(e.illegal));
                chk("trap_take", e.step_no, 32'(bus.trap_take),    32'(e.take));
                if (e.take) chk("trap_pc", e.step_no, bus.trap_pc, e.tpc);
            end
        end
    end

    bit [11:0] addrs [15] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                             12'hF14, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h301, 12'h343};

    initial begin : driver
        int wait_cnt;
        idle_inputs();
        do_reset(0, 0);

        rd(12'h300); rd(12'h342); rd(12'h341); rd(12'h305);
        rd(12'hB00); rd(12'hB00); rd(12'hB00);

        csr(2'b10, 12'h300, 32'h8); rd(12'h300);
        csr(2'b11, 12'h300, 32'h8); rd(12'h300);
        csr(2'b01, 12'h344, 32'hFFF); rd(12'h344);
        csr(2'b10, 12'h344, 32'h0); csr(2'b01, 12'hF14, 32'h1); rd(12'h7C0);
        step(0, 2'b01, 1, 12'h340, 32'h1234, 0, 0, 0, 0, 0, 0); rd(12'h340);

        // Exception entry, direct mode
        csr(2'b01, 12'h305, 32'h8000_0100); csr(2'b10, 12'h300, 32'h8); rd(12'hB02);
        step(1, 2'b00, 0, 12'h000, 0, 32'h8000_0010, 1, 32'd2, 0, 0, 0);
        rd(12'h341); rd(12'h342); rd(12'h300); rd(12'hB02);

        // Vectored interrupt, external beats timer
        csr(2'b01, 12'h305, 32'h8000_0001); csr(2'b01, 12'h304, 32'h880); csr(2'b10, 12'h300, 32'h8);
        step(1, 2'b00, 0, 12'h000, 0, 32'h8000_0040, 0, 0, 0, 1, 1);
        step(1, 2'b00, 1, 12'h342, 0, 32'h8000_0044, 0, 0, 0, 1, 1);
        rd(12'h341);
        step(1, 2'b00, 0, 12'h000, 0, 32'h8000_0048, 0, 0, 1, 0, 0);
        rd(12'h300);
        step(1, 2'b00, 0, 12'h000, 0, 32'h8000_004C, 0, 0, 1, 1, 0);
        rd(12'h342);
        step(1, 2'b00, 0, 12'h000, 0, 32'h8000_0050, 0, 0, 1, 0, 0);

        // Counter carry and write-overrides-increment
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF); rd(12'hB80); rd(12'hB00); rd(12'hB80);
        csr(2'b01, 12'hB00, 32'd5); rd(12'hB00);
        csr(2'b01, 12'hB82, 32'hFFFF_FFFF); csr(2'b01, 12'hB02, 32'hFFFF_FFFE);
        rd(12'hB02); rd(12'hB82); rd(12'hB02);

        // Reset asserted in the same cycle as a trap
        do_reset(1, 1);
        rd(12'h300); rd(12'h341); rd(12'hB00);

        for (int i = 0; i < 600; i++) begin
            bit [1:0]  op;
            bit [31:0] w;
            op = 2'($urandom_range(0, 3));
            w  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) w = w & 32'h888;
            step($urandom_range(0, 9) != 0, op, $urandom_range(0, 3) != 0,
                 addrs[$urandom_range(0, 14)], w, $urandom,
                 $urandom_range(0, 11) == 0, $urandom & 32'h7FFF_FFFF,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
        end

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
